// File: rtl/multi_digit_seg_counter.sv
// multi_digit_seg_counter: prescaled up/down BCD counter with registered active-high 7-segment outputs.
// Define SEG_COUNTER_BLANK_EN to blank leading-zero digits above digit 0.
module multi_digit_seg_counter #(
    parameter int DIGITS = 2,
    parameter int TICK_DIV = 50000000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [7*DIGITS-1:0]   SEG,
    output logic                  WRAP
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0]       pre;
    logic [4*DIGITS-1:0] nxt;
    logic [4*DIGITS-1:0] ld;
    logic                tick;
    logic                carry;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 7'h3F;
            4'd1: enc = 7'h06;
            4'd2: enc = 7'h5B;
            4'd3: enc = 7'h4F;
            4'd4: enc = 7'h66;
            4'd5: enc = 7'h6D;
            4'd6: enc = 7'h7D;
            4'd7: enc = 7'h07;
            4'd8: enc = 7'h7F;
            4'd9: enc = 7'h6F;
            default: enc = 7'h00;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] render(input logic [4*DIGITS-1:0] v);
`ifdef SEG_COUNTER_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        render = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef SEG_COUNTER_BLANK_EN
            // a digit is blanked only while every digit above it is also zero
            lead = lead && (v[4*i+:4] == 4'd0);
            render[7*i+:7] = (lead && i != 0) ? 7'h00 : enc(v[4*i+:4]);
`else
            render[7*i+:7] = enc(v[4*i+:4]);
`endif
        end
    endfunction

    assign tick = EN && (pre == CW'(TICK_DIV - 1));

    // ripple decimal carry/borrow; the final carry flags a full wrap
    always_comb begin
        nxt = BCD;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                nxt[4*i+:4] = UP ? ((BCD[4*i+:4] == 4'd9) ? 4'd0 : BCD[4*i+:4] + 4'd1)
                                 : ((BCD[4*i+:4] == 4'd0) ? 4'd9 : BCD[4*i+:4] - 4'd1);
                carry = (BCD[4*i+:4] == (UP ? 4'd9 : 4'd0));
            end
        end
    end

    always_comb begin
        ld = LOAD_VAL;
        for (int i = 0; i < DIGITS; i++)
            ld[4*i+:4] = (LOAD_VAL[4*i+:4] > 4'd9) ? 4'd9 : LOAD_VAL[4*i+:4];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre  <= '0;
            BCD  <= '0;
            WRAP <= 1'b0;
            SEG  <= render('0);
        end else begin
            WRAP <= 1'b0;
            SEG  <= render(BCD);
            if (LOAD) begin
                BCD <= ld;
                pre <= '0;
            end else if (tick) begin
                BCD  <= nxt;
                pre  <= '0;
                WRAP <= carry;
            end else if (EN) begin
                pre <= pre + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multi_digit_seg_counter.sv
// tb_multi_digit_seg_counter: directed scenarios plus randomized traffic against an integer-valued reference model.
// Build with SEG_COUNTER_BLANK_EN defined to also exercise leading-zero blanking.
module tb_multi_digit_seg_counter;
    localparam int DIGITS = 2;
    localparam int TICK_DIV = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic        UP = 1'b1;
    logic        LOAD = 1'b0;
    logic [7:0]  LOAD_VAL = 8'h00;
    logic [7:0]  BCD;
    logic [13:0] SEG;
    logic        WRAP;

    int vectors = 0;
    int errors = 0;

    // reference model: count as a plain integer 0..99
    int m_val = 0;
    int m_pre = 0;
    int m_shown = 0;
    bit m_wrap = 1'b0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    multi_digit_seg_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .BCD(BCD), .SEG(SEG), .WRAP(WRAP)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    function automatic logic [13:0] to_seg(input int v);
        logic [6:0] hi;
        hi = seg_tab[v / 10];
`ifdef SEG_COUNTER_BLANK_EN
        if (v < 10) hi = 7'h00;
`endif
        return {hi, seg_tab[v % 10]};
    endfunction

    function automatic int load_int(input logic [7:0] lv);
        int hi, lo;
        hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic cyc();
        @(posedge CLK);
        if (RST) begin
            m_val = 0; m_pre = 0; m_wrap = 1'b0; m_shown = 0;
        end else begin
            m_shown = m_val;
            m_wrap = 1'b0;
            if (LOAD) begin
                m_val = load_int(LOAD_VAL);
                m_pre = 0;
            end else if (EN) begin
                if (m_pre == TICK_DIV - 1) begin
                    m_pre = 0;
                    m_wrap = UP ? (m_val == 99) : (m_val == 0);
                    m_val = UP ? (m_val + 1) % 100 : (m_val + 99) % 100;
                end else begin
                    m_pre++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b1; UP = 1'b1; LOAD = 1'b1; LOAD_VAL = 8'h55;
        repeat (5) begin
            cyc();
            vectors++;
            if (BCD !== 8'h00) begin errors++; $display("FAIL reset_bcd got %h want 00", BCD); end
            vectors++;
            if (SEG !== to_seg(0)) begin errors++; $display("FAIL reset_seg got %h want %h", SEG, to_seg(0)); end
            vectors++;
            if (WRAP !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", WRAP); end
        end
        LOAD = 1'b0; LOAD_VAL = 8'h00;
    endtask

    task automatic test_count_up();
        RST = 1'b0; EN = 1'b1; UP = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            vectors++;
            if (BCD !== to_bcd(m_val)) begin errors++; $display("FAIL count_up_bcd k=%0d got %h want %h", k, BCD, to_bcd(m_val)); end
            if (k == 3 || k == 4 || k == 8) begin
                vectors++;
                if (BCD !== (k == 3 ? 8'h00 : k == 4 ? 8'h01 : 8'h02)) begin
                    errors++; $display("FAIL count_up_step k=%0d got %h", k, BCD);
                end
            end
            if (k == 4 || k == 5) begin
                vectors++;
                if (SEG[6:0] !== (k == 4 ? 7'h3F : 7'h06)) begin
                    errors++; $display("FAIL count_up_seg_latency k=%0d got %h", k, SEG[6:0]);
                end
            end
        end
    endtask

    task automatic test_wrap_up();
        int wraps = 0;
        LOAD = 1'b1; LOAD_VAL = 8'h98; EN = 1'b1; UP = 1'b1;
        cyc();
        LOAD = 1'b0;
        vectors++;
        if (BCD !== 8'h98 || WRAP !== 1'b0) begin errors++; $display("FAIL wrap_up_load got %h/%b want 98/0", BCD, WRAP); end
        for (int k = 1; k <= 10; k++) begin
            cyc();
            wraps += int'(WRAP);
            if (k == 4) begin
                vectors++;
                if (BCD !== 8'h99) begin errors++; $display("FAIL wrap_up_99 got %h want 99", BCD); end
            end
            if (k == 8) begin
                vectors++;
                if (BCD !== 8'h00 || WRAP !== 1'b1) begin errors++; $display("FAIL wrap_up_00 got %h/%b want 00/1", BCD, WRAP); end
            end
        end
        vectors++;
        if (wraps != 1) begin errors++; $display("FAIL wrap_up_count got %0d want 1", wraps); end
    endtask

    task automatic test_wrap_down();
        int wraps = 0;
        LOAD = 1'b1; LOAD_VAL = 8'h00; UP = 1'b0;
        cyc();
        LOAD = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            wraps += int'(WRAP);
            if (k == 4) begin
                vectors++;
                if (BCD !== 8'h99 || WRAP !== 1'b1) begin errors++; $display("FAIL wrap_down_99 got %h/%b want 99/1", BCD, WRAP); end
            end
            if (k == 8) begin
                vectors++;
                if (BCD !== 8'h98 || WRAP !== 1'b0) begin errors++; $display("FAIL wrap_down_98 got %h/%b want 98/0", BCD, WRAP); end
            end
        end
        vectors++;
        if (wraps != 1) begin errors++; $display("FAIL wrap_down_count got %0d want 1", wraps); end
    endtask

    task automatic test_load();
        LOAD = 1'b1; LOAD_VAL = 8'hA5; UP = 1'b1; EN = 1'b1;
        cyc();
        LOAD = 1'b0;
        vectors++;
        if (BCD !== 8'h95) begin errors++; $display("FAIL load_clamp got %h want 95", BCD); end
        repeat (3) cyc();
        LOAD = 1'b1; LOAD_VAL = 8'h99;
        cyc();
        LOAD = 1'b0;
        vectors++;
        if (BCD !== 8'h99 || WRAP !== 1'b0) begin errors++; $display("FAIL load_vs_tick got %h/%b want 99/0", BCD, WRAP); end
        repeat (3) cyc();
        vectors++;
        if (BCD !== 8'h99) begin errors++; $display("FAIL load_prescaler_restart got %h want 99", BCD); end
        cyc();
        vectors++;
        if (BCD !== 8'h00 || WRAP !== 1'b1) begin errors++; $display("FAIL load_then_wrap got %h/%b want 00/1", BCD, WRAP); end
        repeat (2) cyc();
        LOAD = 1'b1; LOAD_VAL = 8'h3C;
        cyc();
        LOAD = 1'b0;
        repeat (3) cyc();
        vectors++;
        if (BCD !== 8'h39) begin errors++; $display("FAIL load_midcount_clear got %h want 39", BCD); end
        cyc();
        vectors++;
        if (BCD !== 8'h40) begin errors++; $display("FAIL load_midcount_step got %h want 40", BCD); end
    endtask

    task automatic test_enable_hold();
        EN = 1'b1; UP = 1'b1;
        repeat (2) cyc();
        EN = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            vectors++;
            if (BCD !== 8'h40 || WRAP !== 1'b0) begin errors++; $display("FAIL enable_hold k=%0d got %h want 40", k, BCD); end
        end
        EN = 1'b1;
        cyc();
        vectors++;
        if (BCD !== 8'h40) begin errors++; $display("FAIL enable_resume_early got %h want 40", BCD); end
        cyc();
        vectors++;
        if (BCD !== 8'h41) begin errors++; $display("FAIL enable_resume_step got %h want 41", BCD); end
    endtask

    task automatic test_direction_change();
        repeat (2) cyc();
        UP = 1'b0;
        cyc();
        vectors++;
        if (BCD !== 8'h41) begin errors++; $display("FAIL dir_change_early got %h want 41", BCD); end
        cyc();
        vectors++;
        if (BCD !== 8'h40) begin errors++; $display("FAIL dir_change_step got %h want 40", BCD); end
    endtask

    task automatic test_reset_midcount();
        LOAD = 1'b1; LOAD_VAL = 8'h99; UP = 1'b1; EN = 1'b1;
        cyc();
        LOAD = 1'b0;
        repeat (3) cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        vectors++;
        if (BCD !== 8'h00 || WRAP !== 1'b0) begin errors++; $display("FAIL reset_mid got %h/%b want 00/0", BCD, WRAP); end
        cyc();
        vectors++;
        if (WRAP !== 1'b0 || SEG !== to_seg(0)) begin errors++; $display("FAIL reset_mid_after got %b/%h", WRAP, SEG); end
    endtask

`ifdef SEG_COUNTER_BLANK_EN
    task automatic test_blank();
        EN = 1'b0;
        LOAD = 1'b1; LOAD_VAL = 8'h07;
        repeat (2) cyc();
        LOAD = 1'b0;
        vectors++;
        if (SEG !== 14'h0007) begin errors++; $display("FAIL blank_07 got %h want 0007", SEG); end
        LOAD = 1'b1; LOAD_VAL = 8'h00;
        repeat (2) cyc();
        LOAD = 1'b0;
        vectors++;
        if (SEG !== 14'h003F) begin errors++; $display("FAIL blank_00 got %h want 003F", SEG); end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            RST = ($urandom_range(63) == 0);
            LOAD = ($urandom_range(15) == 0);
            EN = ($urandom_range(3) != 0);
            if ($urandom_range(31) == 0) UP = ~UP;
            LOAD_VAL = 8'($urandom);
            cyc();
            vectors++;
            if (BCD !== to_bcd(m_val)) begin errors++; $display("FAIL rand_bcd k=%0d got %h want %h", k, BCD, to_bcd(m_val)); end
            vectors++;
            if (SEG !== to_seg(m_shown)) begin errors++; $display("FAIL rand_seg k=%0d got %h want %h", k, SEG, to_seg(m_shown)); end
            vectors++;
            if (WRAP !== m_wrap) begin errors++; $display("FAIL rand_wrap k=%0d got %b want %b", k, WRAP, m_wrap); end
        end
        RST = 1'b0; LOAD = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load();
        test_enable_hold();
        test_direction_change();
        test_reset_midcount();
`ifdef SEG_COUNTER_BLANK_EN
        test_blank();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/multi_digit_seg_counter.md
MULTI_DIGIT_SEG_COUNTER -- requirements
Module: multi_digit_seg_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of BCD digits (legal range 1..8).
REQ-002 The block SHALL have parameter TICK_DIV, default 50000000, giving clock cycles per count step (legal range 2 or more).
REQ-003 CLK  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 EN  input  1  count enable; prescaler and counter SHALL hold while low.
REQ-006 UP  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 LOAD  input  1  synchronous load strobe.
REQ-008 LOAD_VAL  input  4*DIGITS  BCD value to load; digit 0 is in bits [3:0].
REQ-009 BCD  output  4*DIGITS  current count, registered.
REQ-010 SEG  output  7*DIGITS  active-high segments per digit, bit order {g,f,e,d,c,b,a}; digit 0 is in bits [6:0].
REQ-011 WRAP  output  1  one-cycle pulse on counter wrap-around.

Function
REQ-012 The prescaler SHALL count 0..TICK_DIV-1 while EN=1, and SHALL assert an internal tick in the cycle it equals TICK_DIV-1, then return to 0.
REQ-013 On a tick with UP=1, the counter SHALL add 1 in BCD with decimal carry between digits.
REQ-014 On a tick with UP=0, the counter SHALL subtract 1 in BCD with decimal borrow between digits.
REQ-015 Wrap from all-9s to 0 (up), or from 0 to all-9s (down), SHALL set WRAP=1 for exactly the cycle after the wrapping edge.
REQ-016 WRAP SHALL be 0 in every other cycle.
REQ-017 BCD SHALL reflect a step one cycle after the tick edge.
REQ-018 SEG SHALL be registered from BCD, giving 1 further cycle of latency (2 cycles total from tick).
REQ-019 Segment codes SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-020 LOAD=1 SHALL load LOAD_VAL into the counter and clear the prescaler, independent of EN.
REQ-021 LOAD SHALL have priority over a coincident tick, and no WRAP SHALL be produced for that cycle.
REQ-022 Any LOAD_VAL digit greater than 9 SHALL be loaded as 9.
REQ-023 A change of UP mid-count SHALL take effect on the next tick; the prescaler SHALL NOT be cleared by it.
REQ-024 EN=0 SHALL freeze both the prescaler and the counter at their current values.

Reset
REQ-025 RST=1 SHALL take priority over LOAD and EN.
REQ-026 On RST=1, the prescaler SHALL clear to 0, BCD to 0, and WRAP to 0.
REQ-027 On RST=1, every SEG digit SHALL go to 3F (or per REQ-029 when blanking is compiled in).
REQ-028 Reset asserted mid-count SHALL discard any pending tick or wrap.

Configuration
REQ-029 With SEG_COUNTER_BLANK_EN defined, leading-zero digits above digit 0 SHALL output SEG=00, and digit 0 SHALL always be displayed.
REQ-030 Without SEG_COUNTER_BLANK_EN defined, all digits SHALL always be displayed, including leading zeros.

Verification (DIGITS=2, TICK_DIV=4)
REQ-031 Scenario: RST high 5 cycles, then low with EN=1, UP=1 -> BCD=00 during reset; 01 after 4 cycles; 02 after 8 cycles; SEG digit 0 = 06 two cycles after the first tick.
REQ-032 Scenario: LOAD 98, then count up -> 99, then 00 with WRAP=1 for one cycle; no other WRAP pulse.
REQ-033 Scenario: LOAD 00 with UP=0, then one tick -> BCD=99 and WRAP pulses once; the next tick gives 98.
REQ-034 Scenario: LOAD_VAL=0xA5 -> BCD=95; LOAD coincident with a tick -> the loaded value wins and the prescaler restarts at 0.
REQ-035 Scenario: EN low for 10 cycles mid-count -> BCD and the prescaler are unchanged; counting resumes with the remaining prescaler cycles.
REQ-036 Scenario: with SEG_COUNTER_BLANK_EN defined, LOAD 07 -> SEG=[00,07]; count 00 -> SEG=[00,3F].
